// File: rtl/wb_arbiter_2to1.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin grant that is held until the owner drops cyc.
// Optional slave watchdog is built in when WB_ARB_TIMEOUT_EN is defined.
module wb_arbiter_2to1 #(
  parameter int ADDR_W         = 32,
  parameter int DAT_W          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic [ADDR_W-1:0]    m0_addr_i,
  output logic [DAT_W-1:0]     m0_dat_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  input  logic [DAT_W/8-1:0]   m1_sel_i,
  input  logic [ADDR_W-1:0]    m1_addr_i,
  input  logic [DAT_W-1:0]     m1_dat_i,
  output logic [DAT_W-1:0]     m1_dat_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [DAT_W/8-1:0]   s_sel_o,
  output logic [ADDR_W-1:0]    s_addr_o,
  output logic [DAT_W-1:0]     s_dat_o,
  input  logic [DAT_W-1:0]     s_dat_i,
  input  logic                 s_ack_i,
  input  logic                 s_err_i
);

  localparam int SEL_W = DAT_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2
  } state_e;

  state_e     state_q;
  logic       last_q;     // 1'b0: M0 received the latest grant, 1'b1: M1
  logic [1:0] req_s;
  logic       tmo_hit_s;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q;
  logic [1:0]       tmo_flag_q;

  assign tmo_hit_s = (state_q != IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYCLES));
  // A timed-out master stays locked out until it drops cyc, so a stuck requester cannot re-grab the bus.
  assign req_s     = {m1_cyc_i & ~tmo_flag_q[1], m0_cyc_i & ~tmo_flag_q[0]};

  // Watchdog counter and per-master sticky timeout flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q      <= '0;
      tmo_flag_q <= 2'b00;
    end else begin
      if ((state_q == IDLE) || tmo_hit_s || s_ack_i || s_err_i) begin
        tmo_q <= '0;
      end else if (s_stb_o) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end else begin
        tmo_q <= tmo_q;
      end
      tmo_flag_q[0] <= m0_cyc_i & (tmo_flag_q[0] | (tmo_hit_s & (state_q == GNT_M0)));
      tmo_flag_q[1] <= m1_cyc_i & (tmo_flag_q[1] | (tmo_hit_s & (state_q == GNT_M1)));
    end
  end
`else
  logic [31:0] unused_tmo_cfg_s;

  assign unused_tmo_cfg_s = 32'(TIMEOUT_CYCLES);
  assign tmo_hit_s        = 1'b0;
  assign req_s            = {m1_cyc_i, m0_cyc_i};
`endif

  // Grant FSM: round-robin on ties, always returns through IDLE between owners
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_s[0] && req_s[1]) begin
            state_q <= last_q ? GNT_M0 : GNT_M1;
            last_q  <= ~last_q;
          end else if (req_s[0]) begin
            state_q <= GNT_M0;
            last_q  <= 1'b0;
          end else if (req_s[1]) begin
            state_q <= GNT_M1;
            last_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            last_q  <= last_q;
          end
        end
        GNT_M0: begin
          state_q <= (!m0_cyc_i || tmo_hit_s) ? IDLE : GNT_M0;
          last_q  <= last_q;
        end
        GNT_M1: begin
          state_q <= (!m1_cyc_i || tmo_hit_s) ? IDLE : GNT_M1;
          last_q  <= last_q;
        end
        default: begin
          state_q <= IDLE;
          last_q  <= last_q;
        end
      endcase
    end
  end

  // Datapath mux; the timeout cycle replaces the slave response with a forced error and drops the bus
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_addr_o = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_q)
      GNT_M0: begin
        s_addr_o = m0_addr_i;
        s_sel_o  = {SEL_W{1'b1}};
        m0_dat_o = s_dat_i;
        if (tmo_hit_s) begin
          m0_err_o = 1'b1;
        end else begin
          s_cyc_o  = m0_cyc_i;
          s_stb_o  = m0_stb_i;
          m0_ack_o = s_ack_i;
          m0_err_o = s_err_i;
        end
      end
      GNT_M1: begin
        s_we_o   = m1_we_i;
        s_addr_o = m1_addr_i;
        s_sel_o  = m1_sel_i;
        s_dat_o  = m1_dat_i;
        m1_dat_o = s_dat_i;
        if (tmo_hit_s) begin
          m1_err_o = 1'b1;
        end else begin
          s_cyc_o  = m1_cyc_i;
          s_stb_o  = m1_stb_i;
          m1_ack_o = s_ack_i;
          m1_err_o = s_err_i;
        end
      end
      default: begin
        s_cyc_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Directed self-checking bench for wb_arbiter_2to1; inputs change and outputs are sampled on the falling edge.
module tb_wb_arbiter_2to1;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m0_cyc_i, m0_stb_i;
  logic [31:0] m0_addr_i, m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_addr_i, m1_dat_i, m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_addr_o, s_dat_o, s_dat_i;
  logic        s_ack_i, s_err_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  wb_arbiter_2to1 #(.ADDR_W(32), .DAT_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_addr_i(m0_addr_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_addr_i(m1_addr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_ni = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 32'h8000_0000;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_sel_i = 4'h0;
    m1_addr_i = 32'h0; m1_dat_i = 32'h0;
    s_dat_i = 32'h0; s_ack_i = 1'b0; s_err_i = 1'b0;

    // Reset held with M0 requesting
    step();
    check_eq("rst_cyc", s_cyc_o, 1'b0);
    check_eq("rst_addr", s_addr_o, 32'h0);
    check_eq("rst_sel", s_sel_o, 4'h0);
    rst_ni = 1'b1;
    #1 check_eq("rel_idle_cyc", s_cyc_o, 1'b0);
    step();
    check_eq("m0_gnt_cyc", s_cyc_o, 1'b1);
    check_eq("m0_gnt_addr", s_addr_o, 32'h8000_0000);
    check_eq("m0_gnt_sel", s_sel_o, 4'hF);
    check_eq("m0_gnt_we", s_we_o, 1'b0);
    check_eq("m0_gnt_dat", s_dat_o, 32'h0);
    s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    #1 check_eq("m0_ack", m0_ack_o, 1'b1);
    check_eq("m0_rdat", m0_dat_o, 32'h1234_5678);
    check_eq("m1_noack", m1_ack_o, 1'b0);
    check_eq("m1_nodat", m1_dat_o, 32'h0);
    step();
    s_ack_i = 1'b0; s_dat_i = 32'h0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;

    // Fresh reset, both masters request together: M1 wins first
    rst_ni = 1'b0;
    #1 m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_sel_i = 4'hF;
    m1_addr_i = 32'h0000_0010; m1_dat_i = 32'hDEAD_BEEF;
    rst_ni = 1'b1;
    step();
    check_eq("tie_m1_addr", s_addr_o, 32'h0000_0010);
    check_eq("tie_m1_we", s_we_o, 1'b1);
    check_eq("tie_m1_wdat", s_dat_o, 32'hDEAD_BEEF);
    check_eq("wr_c1_ack", m1_ack_o, 1'b0);
    step();
    check_eq("wr_c2_ack", m1_ack_o, 1'b0);
    step();
    s_ack_i = 1'b1;
    #1 check_eq("wr_c3_ack", m1_ack_o, 1'b1);
    check_eq("wr_c3_m0ack", m0_ack_o, 1'b0);
    check_eq("wr_c3_sel", s_sel_o, 4'hF);
    s_err_i = 1'b1;
    #1 check_eq("ackerr_err", m1_err_o, 1'b1);
    check_eq("ackerr_ack", m1_ack_o, 1'b1);
    check_eq("ackerr_m0err", m0_err_o, 1'b0);
    s_ack_i = 1'b0; s_err_i = 1'b0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;

    // Dead IDLE cycle: slave inputs must not leak
    step();
    s_ack_i = 1'b1; s_err_i = 1'b1;
    #1 check_eq("idle_cyc", s_cyc_o, 1'b0);
    check_eq("idle_m0ack", m0_ack_o, 1'b0);
    check_eq("idle_m1ack", m1_ack_o, 1'b0);
    check_eq("idle_m0err", m0_err_o, 1'b0);
    s_ack_i = 1'b0; s_err_i = 1'b0;
    step();
    check_eq("m0_after_idle", s_addr_o, 32'h8000_0000);

    // M1 requests while M0 owns: no preemption, no leakage to M1
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_addr_i = 32'h0000_0020;
    for (int i = 0; i < 3; i++) begin
      s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
      #1 check_eq("hold_addr", s_addr_o, 32'h8000_0000);
      check_eq("hold_m1ack", m1_ack_o, 1'b0);
      check_eq("hold_m1dat", m1_dat_o, 32'h0);
      check_eq("hold_m0dat", m0_dat_o, 32'h1234_5678);
      step();
    end
    s_ack_i = 1'b0; s_dat_i = 32'h0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step();
    check_eq("handover_idle", s_cyc_o, 1'b0);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    step();
    check_eq("tie2_m1_addr", s_addr_o, 32'h0000_0020);
    check_eq("tie2_m1_cyc", s_cyc_o, 1'b1);

    // Asynchronous reset mid-transfer with the slave acking
    s_ack_i = 1'b1; s_dat_i = 32'hA5A5_A5A5;
    #2 rst_ni = 1'b0;
    #1 check_eq("arst_cyc", s_cyc_o, 1'b0);
    check_eq("arst_stb", s_stb_o, 1'b0);
    check_eq("arst_m1ack", m1_ack_o, 1'b0);
    check_eq("arst_addr", s_addr_o, 32'h0);
    check_eq("arst_m1dat", m1_dat_o, 32'h0);
    step();
    s_ack_i = 1'b0; s_dat_i = 32'h0;
    rst_ni = 1'b1;
    #1 check_eq("arst_idle", s_cyc_o, 1'b0);
    step();
    check_eq("arst_tie_m1", s_addr_o, 32'h0000_0020);

`ifdef WB_ARB_TIMEOUT_EN
    begin
      logic seen;
      logic cyc_at_err;
      seen = 1'b0;
      cyc_at_err = 1'b1;
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      step();
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      step();
      check_eq("tmo_m0_gnt", s_addr_o, 32'h8000_0000);
      for (int i = 0; i < 10; i++) begin
        if (!seen) begin
          if (m0_err_o) begin
            seen = 1'b1;
            cyc_at_err = s_cyc_o;
          end else begin
            step();
          end
        end
      end
      check_eq("tmo_err_seen", seen, 1'b1);
      check_eq("tmo_err_cyc", cyc_at_err, 1'b0);
      step();
      check_eq("tmo_idle_cyc", s_cyc_o, 1'b0);
      check_eq("tmo_err_once", m0_err_o, 1'b0);
      step();
      check_eq("tmo_m1_cyc", s_cyc_o, 1'b1);
      check_eq("tmo_m1_addr", s_addr_o, 32'h0000_0020);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2to1.md
Name: wb_arbiter_2to1

Overview:
- Two-master, one-slave Wishbone classic arbiter.
- Sits between the core's instruction port (iwbm_*) and data port (dwbm_*) and one shared memory/peripheral bus, so a single-ported memory can serve both pipeline stages.
- Grants are round-robin and locked for the full cycle.
- Slave responses are routed only to the current owner.

Parameters:
- ADDR_W, 32, address width.
- DAT_W, 32, data width; sel width is DAT_W/8.
- TIMEOUT_CYCLES, 255, watchdog limit. Used only with WB_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- m0_cyc_i  in  1  instruction master cycle
- m0_stb_i  in  1  instruction master strobe
- m0_addr_i  in  ADDR_W  instruction address
- m0_dat_o  out  DAT_W  read data to instruction master
- m0_ack_o  out  1  ack to instruction master
- m0_err_o  out  1  error to instruction master
- m1_cyc_i  in  1  data master cycle
- m1_stb_i  in  1  data master strobe
- m1_we_i  in  1  data master write enable
- m1_sel_i  in  DAT_W/8  byte selects
- m1_addr_i  in  ADDR_W  data address
- m1_dat_i  in  DAT_W  write data
- m1_dat_o  out  DAT_W  read data to data master
- m1_ack_o  out  1  ack to data master
- m1_err_o  out  1  error to data master
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_we_o  out  1  slave write enable
- s_sel_o  out  DAT_W/8  slave byte selects
- s_addr_o  out  ADDR_W  slave address
- s_dat_o  out  DAT_W  slave write data
- s_dat_i  in  DAT_W  slave read data
- s_ack_i  in  1  slave ack
- s_err_i  in  1  slave error

Behaviour:
- Reset:
  - State IDLE; last_grant=M0 (so the first tie goes to M1); timeout counter 0.
  - All *_ack_o, *_err_o, s_cyc_o, s_stb_o, s_we_o = 0.
  - s_sel_o, s_addr_o, s_dat_o, m0_dat_o, m1_dat_o = 0.
  - Reset asserted mid-transfer aborts the transfer immediately. No ack/err is emitted.
- States: IDLE, GNT_M0, GNT_M1. State and last_grant are registered; the datapath mux is combinational from state.
- IDLE:
  - Only m0_cyc_i=1: go to GNT_M0.
  - Only m1_cyc_i=1: go to GNT_M1.
  - Both: grant the master that is not last_grant.
  - Neither: stay in IDLE.
  - last_grant updates when a grant is issued.
- GNT_Mx:
  - s_cyc_o = mx_cyc_i, s_stb_o = mx_stb_i.
  - s_addr_o/s_we_o/s_sel_o/s_dat_o come from Mx. M0 drives we=0, sel=all ones, dat=0.
  - mx_ack_o=s_ack_i, mx_err_o=s_err_i, mx_dat_o=s_dat_i.
  - The non-owner sees ack=err=0, dat=0.
- Release: mx_cyc_i=0 at a clock edge moves GNT_Mx to IDLE.
  - IDLE always lasts at least one cycle, so there is one dead cycle between owners.
  - Back-to-back cycles by the same master also pass through IDLE.
- Latency:
  - Request to s_cyc_o: 1 clock, because the grant is registered.
  - Slave ack to master ack: 0 clocks, combinational.
- In IDLE: s_cyc_o=s_stb_o=0 and both masters see ack=err=0, regardless of slave inputs.
- Simultaneous s_ack_i and s_err_i: both pass through unchanged. The master resolves them.
- No preemption: a granted master keeps the bus until it drops cyc, even if the other master waits.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro:
  - A counter increments each cycle in GNT_Mx while s_stb_o=1 and s_ack_i=s_err_i=0.
  - The counter clears on ack/err or on leaving GNT_Mx.
  - When the counter reaches TIMEOUT_CYCLES, the arbiter drives mx_err_o=1 for exactly one cycle.
  - In that same cycle s_cyc_o=s_stb_o=0.
  - Next state is IDLE regardless of mx_cyc_i.
  - A sticky timeout flag is then cleared on the owner's next cycle drop.
- Without the macro: no counter exists, and a hung slave holds the bus indefinitely.

Test Plan:
- Reset with m0_cyc_i=1 asserted -> after rst_ni rises: first edge gives GNT_M0, s_cyc_o=1 one cycle later, s_addr_o=m0_addr_i (e.g. 0x8000_0000).
- m0 and m1 request together from IDLE after reset -> M1 is granted first. After M1 drops cyc: one IDLE cycle, then M0 is granted. A second simultaneous request afterwards grants M1.
- M1 write to 0x0000_0010, dat 0xDEADBEEF, sel 0xF; slave acks on the 3rd cycle -> m1_ack_o=1 in that same cycle, m0_ack_o=0 throughout, s_we_o=1.
- M0 owns the bus and M1 requests mid-transfer -> M1 is not granted until M0 drops cyc. M1 sees no ack while waiting; s_dat_i=0x12345678 appears only on m0_dat_o.
- rst_ni pulled low while GNT_M1 with stb pending -> all outputs are 0 asynchronously, no ack leaks, state is IDLE.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never acks an M0 read -> m0_err_o=1 for one cycle, s_cyc_o=0 in that cycle, then IDLE; a pending M1 request is granted on the following cycle.
